// File: rtl/led_rgb_scan.sv
// led_rgb_scan: 7-LED RGB multiplex scanner with PWM per colour slot.
// Double-buffered duty banks; shadow copied to active at frame end.
module led_rgb_scan #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 4,
  parameter int BLANK    = 16
) (
  input  logic                    clk30,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [2:0]              wr_led,
  input  logic [3*PWM_BITS-1:0]   wr_rgb,
  input  logic                    wr_commit,
  output logic [6:0]              led_rgb_multiplex_a,
  output logic [2:0]              led_rgb_multiplex_b,
  output logic                    frame_start
);

  localparam int BW = $clog2(BLANK + 1);
  localparam int PW = $clog2(PRESCALE + 1);

  typedef enum logic {
    S_BLANK,
    S_ON
  } state_t;

  typedef enum logic [1:0] {
    C_R = 2'd0,
    C_G = 2'd1,
    C_B = 2'd2
  } col_t;

  state_t              r_state, w_state;
  col_t                r_col, w_col;
  logic [BW-1:0]       r_bcnt, w_bcnt;
  logic [PW-1:0]       r_pcnt, w_pcnt;
  logic [PWM_BITS-1:0] r_step, w_step;
  logic                r_run;
  logic                r_pend, w_pend;
  logic                w_copy;
  logic                w_wr_acc;
  logic                w_cm_acc;
  logic [6:0]          w_a;
  logic [2:0]          w_b;
  logic                w_fs;

  logic [PWM_BITS-1:0] r_shd [7][3];
  logic [PWM_BITS-1:0] r_act [7][3];

  logic [6:0]          r_a;
  logic [2:0]          r_b;
  logic                r_fs;
  logic                r_ready;

  assign w_wr_acc = wr_valid & r_ready;
  assign w_cm_acc = wr_commit & r_ready;

  // Scan FSM state, counters, run flag and commit flag.
  always_ff @(posedge clk30 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BLANK;
      r_col   <= C_R;
      r_bcnt  <= '0;
      r_pcnt  <= '0;
      r_step  <= '0;
      r_run   <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_col   <= w_col;
      r_bcnt  <= w_bcnt;
      r_pcnt  <= w_pcnt;
      r_step  <= w_step;
      r_run   <= 1'b1;
      r_pend  <= w_pend;
    end
  end

  // Next-state, commit and next-output logic; outputs follow next state.
  always_comb begin
    w_state = r_state;
    w_col   = r_col;
    w_bcnt  = r_bcnt;
    w_pcnt  = r_pcnt;
    w_step  = r_step;
    w_copy  = 1'b0;
    w_pend  = r_pend;
    w_a     = '0;
    w_b     = 3'b111;
    w_fs    = 1'b0;

    if (r_run) begin
      unique case (r_state)
        S_BLANK: begin
          if (r_bcnt == BW'(BLANK - 1)) begin
            w_state = S_ON;
            w_bcnt  = '0;
            w_pcnt  = '0;
            w_step  = '0;
          end else begin
            w_bcnt = r_bcnt + 1'b1;
          end
        end
        S_ON: begin
          if (r_pcnt == PW'(PRESCALE - 1)) begin
            w_pcnt = '0;
            if (r_step == '1) begin
              w_state = S_BLANK;
              w_bcnt  = '0;
              w_step  = '0;
              unique case (r_col)
                C_R:     w_col = C_G;
                C_G:     w_col = C_B;
                default: w_col = C_R;
              endcase
              w_copy = (r_col == C_B) & r_pend;
            end else begin
              w_step = r_step + 1'b1;
            end
          end else begin
            w_pcnt = r_pcnt + 1'b1;
          end
        end
        default: w_state = S_BLANK;
      endcase
    end

    if (w_cm_acc) begin
      w_pend = 1'b1;
    end else if (w_copy) begin
      w_pend = 1'b0;
    end

    if (w_state == S_ON) begin
      unique case (w_col)
        C_R: begin
          w_b = 3'b110;
          for (int i = 0; i < 7; i++) w_a[i] = w_step < r_act[i][0];
        end
        C_G: begin
          w_b = 3'b101;
          for (int i = 0; i < 7; i++) w_a[i] = w_step < r_act[i][1];
        end
        default: begin
          w_b = 3'b011;
          for (int i = 0; i < 7; i++) w_a[i] = w_step < r_act[i][2];
        end
      endcase
    end

    w_fs = r_run && (r_state == S_ON) && (w_state == S_BLANK)
        && (w_col == C_R);
  end

  // Shadow writes and end-of-frame shadow-to-active copy.
  always_ff @(posedge clk30 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) begin
        for (int c = 0; c < 3; c++) begin
          r_shd[i][c] <= '0;
          r_act[i][c] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (w_wr_acc && (wr_led == 3'(i))) begin
          r_shd[i][0] <= wr_rgb[3*PWM_BITS-1:2*PWM_BITS];
          r_shd[i][1] <= wr_rgb[2*PWM_BITS-1:PWM_BITS];
          r_shd[i][2] <= wr_rgb[PWM_BITS-1:0];
        end
        if (w_copy) begin
          for (int c = 0; c < 3; c++) r_act[i][c] <= r_shd[i][c];
        end
      end
    end
  end

  // Registered outputs, blanked asynchronously by reset.
  always_ff @(posedge clk30 or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= 3'b111;
      r_fs    <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_a     <= w_a;
      r_b     <= w_b;
      r_fs    <= w_fs;
      r_ready <= ~w_pend;
    end
  end

  assign led_rgb_multiplex_a = r_a;
  assign led_rgb_multiplex_b = r_b;
  assign frame_start         = r_fs;
  assign wr_ready            = r_ready;

endmodule

// File: tb/tb_led_rgb_scan.sv
// tb_led_rgb_scan: directed vector bench for led_rgb_scan.
// Default parameters: 16 blank + 1024 on cycles per slot.
module tb_led_rgb_scan;

  logic        clk30 = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_led = '0;
  logic [23:0] wr_rgb = '0;
  logic        wr_commit = 1'b0;
  logic [6:0]  a;
  logic [2:0]  b;
  logic        frame_start;

  led_rgb_scan dut (
    .clk30               (clk30),
    .rst_n               (rst_n),
    .wr_valid            (wr_valid),
    .wr_ready            (wr_ready),
    .wr_led              (wr_led),
    .wr_rgb              (wr_rgb),
    .wr_commit           (wr_commit),
    .led_rgb_multiplex_a (a),
    .led_rgb_multiplex_b (b),
    .frame_start         (frame_start)
  );

  always #5 clk30 = ~clk30;

  typedef struct {
    logic [2:0]  led;
    logic [23:0] rgb;
    bit          same;
  } vec_t;

  vec_t vt [6];
  int   shd [8][3];
  int   act [7][3];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(string name, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk30);
    #1;
  endtask

  task automatic startup();
    int first_on = -1;
    int first_fs = -1;
    int r_on = 0;
    int g_on = 0;
    int a_hi = 0;
    int rdy0 = 0;
    int b0 = 0;
    int b1040 = 0;
    for (int k = 0; k <= 3120; k++) begin
      step();
      if (k == 0) begin
        rdy0 = wr_ready;
        b0   = b;
      end
      if (k == 1040) b1040 = b;
      if (b == 3'b110) begin
        r_on++;
        if (first_on < 0) first_on = k;
      end
      if (b == 3'b101) g_on++;
      if (a != 7'h00) a_hi++;
      if (frame_start && first_fs < 0) first_fs = k;
    end
    chk("ready_after_release", rdy0, 1);
    chk("b_blank_cycle0", b0, 7);
    chk("first_on_cycle", first_on, 16);
    chk("r_on_cycles", r_on, 1024);
    chk("g_on_cycles", g_on, 1024);
    chk("b_blank_cycle1040", b1040, 7);
    chk("a_zero_first_frame", a_hi, 0);
    chk("first_frame_start", first_fs, 3120);
  endtask

  task automatic do_write(logic [2:0] led, logic [23:0] rgb, bit cm);
    chk("ready_before_write", wr_ready, 1);
    wr_valid  = 1'b1;
    wr_led    = led;
    wr_rgb    = rgb;
    wr_commit = cm;
    step();
    wr_valid  = 1'b0;
    wr_commit = 1'b0;
    if (led < 3'd7) begin
      shd[led][0] = int'(rgb[23:16]);
      shd[led][1] = int'(rgb[15:8]);
      shd[led][2] = int'(rgb[7:0]);
    end
  endtask

  task automatic do_commit();
    chk("ready_before_commit", wr_ready, 1);
    wr_commit = 1'b1;
    step();
    wr_commit = 1'b0;
  endtask

  task automatic wait_copy();
    bit found = 0;
    chk("ready_low_pending", wr_ready, 0);
    wr_valid  = 1'b1;
    wr_led    = 3'd3;
    wr_rgb    = 24'hFFFFFF;
    wr_commit = 1'b1;
    step();
    step();
    wr_valid  = 1'b0;
    wr_commit = 1'b0;
    for (int k = 0; k < 3200; k++) begin
      if (wr_ready) begin
        found = 1;
        break;
      end
      step();
    end
    chk("copy_seen", found, 1);
    chk("fs_at_copy", frame_start, 1);
    for (int i = 0; i < 7; i++)
      for (int c = 0; c < 3; c++) act[i][c] = shd[i][c];
  endtask

  task automatic measure(int v);
    int cnt [7][3];
    int bad = 0;
    int c;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 3; j++) cnt[i][j] = 0;
    for (int k = 0; k < 3120; k++) begin
      if (k > 0) step();
      c = -1;
      case (b)
        3'b110: c = 0;
        3'b101: c = 1;
        3'b011: c = 2;
        3'b111: if (a != 7'h00) bad++;
        default: bad++;
      endcase
      if (c >= 0)
        for (int i = 0; i < 7; i++) if (a[i]) cnt[i][c]++;
    end
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("v%0d_led%0d_col%0d_lit", v, i, j),
            cnt[i][j], act[i][j] * 4);
    chk($sformatf("v%0d_blank_clean", v), bad, 0);
  endtask

  initial begin
    bit seen_on;
    vt[0] = '{3'd7, 24'hFFFFFF, 1'b0};
    vt[1] = '{3'd2, 24'h8000FF, 1'b0};
    vt[2] = '{3'd0, 24'h014000, 1'b1};
    vt[3] = '{3'd6, 24'hFF7F02, 1'b0};
    vt[4] = '{3'd2, 24'h000000, 1'b0};
    vt[5] = '{3'd7, 24'h123456, 1'b1};
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < 3; c++) shd[i][c] = 0;
    for (int i = 0; i < 7; i++)
      for (int c = 0; c < 3; c++) act[i][c] = 0;

    repeat (3) step();
    chk("rst_a", a, 0);
    chk("rst_b", b, 7);
    chk("rst_fs", frame_start, 0);
    chk("rst_ready", wr_ready, 0);

    @(negedge clk30);
    rst_n = 1'b1;
    startup();

    for (int v = 0; v < 6; v++) begin
      do_write(vt[v].led, vt[v].rgb, vt[v].same);
      if (!vt[v].same) do_commit();
      wait_copy();
      measure(v);
    end

    seen_on = 0;
    for (int k = 0; k < 4000; k++) begin
      if (b == 3'b011) begin
        seen_on = 1;
        break;
      end
      step();
    end
    chk("reach_on_before_reset", seen_on, 1);
    repeat (37) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", a, 0);
    chk("async_rst_b", b, 7);
    chk("async_rst_ready", wr_ready, 0);
    repeat (3) step();
    chk("held_rst_fs", frame_start, 0);
    @(negedge clk30);
    rst_n = 1'b1;
    startup();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_rgb_scan.md
LED_RGB_SCAN -- requirements
Module: led_rgb_scan

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8: duty resolution in bits; one PWM period is 2^PWM_BITS steps.
REQ-002 SHALL have parameter PRESCALE, default 4: clk30 cycles per PWM step, minimum 1.
REQ-003 SHALL have parameter BLANK, default 16: blanking cycles before each colour slot, minimum 1.
REQ-004 SHALL have port clk30, input, 1 bit: the single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port wr_valid, input, 1 bit: a shadow-register write is offered.
REQ-007 SHALL have port wr_ready, output, 1 bit: a write or commit can be accepted.
REQ-008 SHALL have port wr_led, input, 3 bits: LED index 0..6.
REQ-009 SHALL have port wr_rgb, input, 3*PWM_BITS bits: duty values {R,G,B}, with R in the MSBs.
REQ-010 SHALL have port wr_commit, input, 1 bit: request a shadow-to-active copy at the end of the frame.
REQ-011 SHALL have port led_rgb_multiplex_a, output, 7 bits: per-LED drive, 1 = lit.
REQ-012 SHALL have port led_rgb_multiplex_b, output, 3 bits: colour select, one-hot active-low, bit0=R, bit1=G, bit2=B.
REQ-013 SHALL have port frame_start, output, 1 bit: one-cycle pulse at the start of each frame.

Function
REQ-014 SHALL hold two banks of 7x3 duty registers, each PWM_BITS wide: a shadow bank (written) and an active bank (displayed).
REQ-015 SHALL accept a write when wr_valid && wr_ready, storing wr_rgb into shadow[wr_led]; wr_led=7 is accepted and discarded.
REQ-016 SHALL scan the colours as slots in the order R, G, B, then repeat; 3 slots form one frame.
REQ-017 SHALL implement a two-state FSM per slot:
- BLANK (BLANK cycles) -> ON (2^PWM_BITS*PRESCALE cycles) -> BLANK of the next colour.
REQ-018 SHALL drive, in BLANK: led_rgb_multiplex_a=7'h00 and led_rgb_multiplex_b=3'b111.
REQ-019 SHALL drive, in ON for colour c: led_rgb_multiplex_b with bit c low and the other bits high.
REQ-020 SHALL, in ON, hold step count p (0..2^PWM_BITS-1) for PRESCALE cycles each; led_rgb_multiplex_a[i]=1 iff p < active[i][c].
- Consequence: duty 0 = never lit; duty 2^PWM_BITS-1 = lit for all steps except the last.
REQ-021 SHALL make outputs registered and glitch-free; a and b change only on the same clk30 edge as the state/step change that drives them.
REQ-022 SHALL assert frame_start for exactly the first cycle of each R-slot BLANK, except the first R-slot BLANK after reset.
REQ-023 SHALL, on an accepted wr_commit (wr_commit && wr_ready), set commit_pending; wr_ready SHALL be 0 while commit_pending=1.
REQ-024 SHALL, on the last ON cycle of the B slot with commit_pending=1, copy all of shadow into active and clear commit_pending the next cycle.
REQ-025 SHALL, when wr_valid and wr_commit are accepted in the same cycle, include that write in the committed data.
REQ-026 SHALL ignore writes and commits presented while wr_ready=0; the write handshake SHALL NOT affect scan timing.

Reset
REQ-027 SHALL, while rst_n=0, force:
- led_rgb_multiplex_a=7'h00, led_rgb_multiplex_b=3'b111, frame_start=0, wr_ready=0;
- both banks all zero, commit_pending=0, FSM=BLANK, colour=R, counters=0.
REQ-028 SHALL set wr_ready=1 on the first clk30 edge after rst_n rises; scanning SHALL start at R BLANK cycle 0 on that edge.
REQ-029 SHALL, on reset asserted mid-slot or mid-commit, blank the outputs immediately (asynchronously) and discard any pending commit.

Verification
REQ-030 Reset release with defaults -> 16 blank cycles, then 1024 cycles with b=3'b110 and a=0; first frame_start at cycle 3120.
REQ-031 Write LED2 = {8'h80,8'h00,8'hFF}, then commit -> from the next frame: R slot a[2] high for the first 512 ON cycles; G slot never high; B slot high for 1020 cycles.
REQ-032 Write plus commit in the same cycle for LED0 -> that value is displayed from the next frame; wr_ready stays low until the copy completes.
REQ-033 Write with wr_led=7, then commit -> active bank unchanged; all a outputs stay 0.
REQ-034 Second commit while pending, and writes while wr_ready=0 -> no effect; the shadow bank is unchanged after the copy.
REQ-035 rst_n pulsed low mid-ON slot -> a=0 and b=3'b111 asynchronously; active bank zero; timing restarts per REQ-030.
